// File: rtl/alu_pkg.sv
// Shared definitions for the miniRISC execute-stage ALU: ALUcodes, FSM states, flag bit positions.
// Build option ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter instead of the serial one.
package alu_pkg;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_DIFF = 4'b0100;
  localparam logic [3:0] ALU_COMP = 4'b0101;
  localparam logic [3:0] ALU_SHLL = 4'b0110;
  localparam logic [3:0] ALU_SHRL = 4'b0111;
  localparam logic [3:0] ALU_SHRA = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_COUNT = 4;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SHLL) || (code == ALU_SHRL) || (code == ALU_SHRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Serial shifter: loads an operand and amount, then moves one bit per cycle until the count runs out.
// Used only when ALU_BARREL_SHIFT_EN is undefined.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int W       = 32,
  parameter int SHAMT_W = $clog2(W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [3:0]         op,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [W-1:0]       data_in,
  output logic [W-1:0]       data,
  output logic               done
);

  logic [W-1:0]       value;
  logic [SHAMT_W-1:0] count;
  logic [3:0]         op_q;
  logic [W-1:0]       step;

  always_comb begin
    step = value;
    case (op_q)
      ALU_SHLL: step = {value[W-2:0], 1'b0};
      ALU_SHRL: step = {1'b0, value[W-1:1]};
      ALU_SHRA: step = {value[W-1], value[W-1:1]};
      default:  step = value;
    endcase
  end

  // data is the value after this cycle's step, so the top can capture it on the final step
  assign data = step;
  assign done = (count == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      count <= '0;
      op_q  <= ALU_PASS;
    end else if (load) begin
      value <= data_in;
      count <= amount;
      op_q  <= op;
    end else if (count != '0) begin
      value <= step;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; shifts are serial (1 bit/cycle) unless
// ALU_BARREL_SHIFT_EN is defined, in which case every operation completes in one cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int W       = 32,
  parameter int SHAMT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_code,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_carry,
  output logic         flag_zero,
  output logic         flag_sign,
  output logic         flag_ovf,
  output logic         illegal_op
);

  alu_state_e state_q, state_d;

  logic [SHAMT_W-1:0]    amount;
  logic [W:0]            sum, diff;
  logic [W-1:0]          shift_comb;
  logic [W-1:0]          comb_result;
  logic [FLAG_COUNT-1:0] comb_flags;
  logic                  comb_illegal;
  logic [W-1:0]          shift_data;
  logic                  shift_done;
  logic                  accept;
  logic [W-1:0]          result_q;
  logic [FLAG_COUNT-1:0] flags_q;
  logic                  illegal_q;

  assign amount = op_b[SHAMT_W-1:0];
  assign accept = in_valid && (state_q == IDLE);
  assign sum    = {1'b0, op_a} + {1'b0, op_b};
  assign diff   = {1'b0, op_a} - {1'b0, op_b};

`ifdef ALU_BARREL_SHIFT_EN
  always_comb begin
    shift_comb = op_a;
    case (alu_code)
      ALU_SHLL: shift_comb = op_a << amount;
      ALU_SHRL: shift_comb = op_a >> amount;
      ALU_SHRA: shift_comb = $signed(op_a) >>> amount;
      default:  shift_comb = op_a;
    endcase
  end

  assign shift_data = '0;
  assign shift_done = 1'b0;
`else
  // Only the zero-amount case completes straight from IDLE, so the result is op_a unchanged
  assign shift_comb = op_a;

  alu_serial_shifter #(
    .W       (W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && is_shift(alu_code) && (amount != '0)),
    .op      (alu_code),
    .amount  (amount),
    .data_in (op_a),
    .data    (shift_data),
    .done    (shift_done)
  );
`endif

  always_comb begin
    comb_result  = '0;
    comb_flags   = '0;
    comb_illegal = 1'b0;
    case (alu_code)
      ALU_PASS: comb_result = op_a;
      ALU_ADD: begin
        comb_result            = sum[W-1:0];
        comb_flags[FLAG_CARRY] = sum[W];
        comb_flags[FLAG_OVF]   = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
      end
      ALU_AND:  comb_result = op_a & op_b;
      ALU_XOR:  comb_result = op_a ^ op_b;
      ALU_DIFF: begin
        comb_result            = diff[W-1:0];
        comb_flags[FLAG_CARRY] = diff[W];
        comb_flags[FLAG_OVF]   = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);
      end
      ALU_COMP: comb_result = ~op_b + W'(1);
      ALU_SHLL, ALU_SHRL, ALU_SHRA: comb_result = shift_comb;
      default:  comb_illegal = 1'b1;
    endcase
    comb_flags[FLAG_ZERO] = (comb_result == '0);
    comb_flags[FLAG_SIGN] = comb_result[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_BARREL_SHIFT_EN
          state_d = DONE;
`else
          state_d = (is_shift(alu_code) && (amount != '0)) ? SHIFT : DONE;
`endif
        end
      end
      SHIFT:   if (shift_done) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result and flags are captured only on DONE entry, so they stay frozen while back-pressured
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else if (accept && (state_d == DONE)) begin
      result_q  <= comb_result;
      flags_q   <= comb_flags;
      illegal_q <= comb_illegal;
    end else if ((state_q == SHIFT) && shift_done) begin
      result_q             <= shift_data;
      flags_q              <= '0;
      flags_q[FLAG_ZERO]   <= (shift_data == '0);
      flags_q[FLAG_SIGN]   <= shift_data[W-1];
      illegal_q            <= 1'b0;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign flag_carry = flags_q[FLAG_CARRY];
  assign flag_zero  = flags_q[FLAG_ZERO];
  assign flag_sign  = flags_q[FLAG_SIGN];
  assign flag_ovf   = flags_q[FLAG_OVF];
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table with a scoreboard queue, plus
// hand-written back-pressure and mid-shift reset sequences.
module tb_alu_exec_unit;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c, z, s, v, ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        c, z, s, v, ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_carry, flag_zero, flag_sign, flag_ovf, illegal_op;

  int    checks;
  int    errors;
  string tag;
  exp_t  sb[$];
  vec_t  vecs[19];

  alu_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_code   (alu_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .flag_sign  (flag_sign),
    .flag_ovf   (flag_ovf),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s actual=%0h required=%0h", tag, name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] code, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (code == 4'b0110 || code == 4'b0111 || code == 4'b1000) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic apply_stimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                input exp_t e, input bit push);
    @(negedge clk);
    in_valid = 1'b1;
    alu_code = code;
    op_a     = a;
    op_b     = b;
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Leaves the bench on the negedge of the first cycle with out_valid high
  task automatic wait_valid(input int lat);
    int cycles;
    bit busy;
    cycles = 0;
    busy   = 1'b0;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (in_ready) busy = 1'b1;
      if (out_valid) break;
    end
    check("latency", cycles, lat);
    check("busy_in_ready", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("out_valid", {31'b0, out_valid}, 32'd1);
      check("result", result, e.res);
      check("carry", {31'b0, flag_carry}, {31'b0, e.c});
      check("zero", {31'b0, flag_zero}, {31'b0, e.z});
      check("sign", {31'b0, flag_sign}, {31'b0, e.s});
      check("ovf", {31'b0, flag_ovf}, {31'b0, e.v});
      check("illegal", {31'b0, illegal_op}, {31'b0, e.ill});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic c, input logic z,
                              input logic s, input logic v, input logic ill);
    exp_t e;
    e.res = res; e.c = c; e.z = z; e.s = s; e.v = v; e.ill = ill;
    return e;
  endfunction

  initial begin
    exp_t e;
    bit   stale;
    checks    = 0;
    errors    = 0;
    tag       = "reset";
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_code  = 4'b0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b0;

    //          code     a             b             result        c     z     s     v     ill
    vecs[0]  = '{4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'b0100, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0011, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0011, 32'h00000000, 32'h80000001, 32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b0101, 32'h11111111, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0101, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'b0101, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b0100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{4'b1000, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'b0110, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'b0111, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'b0110, 32'h00000003, 32'hFFFFFFE1, 32'h00000006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'b1000, 32'h40000000, 32'h00000002, 32'h10000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{4'b1111, 32'h00000005, 32'h00000007, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{4'b0100, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, 32'd1);
    check("out_valid", {31'b0, out_valid}, 32'd0);
    check("result", result, 32'd0);
    check("flags", {27'b0, flag_carry, flag_zero, flag_sign, flag_ovf, illegal_op}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      tag = $sformatf("vec%0d", i);
      e = mk(vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].s, vecs[i].v, vecs[i].ill);
      apply_stimulus(vecs[i].code, vecs[i].a, vecs[i].b, e, 1'b1);
      wait_valid(exp_latency(vecs[i].code, vecs[i].b));
      check_output();
    end

    // Back-pressure: result frozen while a new request is waved at the busy unit
    tag = "backpressure";
    apply_stimulus(4'b0001, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    wait_valid(1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      alu_code = 4'b0011;
      op_a     = 32'h10 + 32'(i);
      op_b     = 32'h3;
      check("hold_result", result, 32'h80000000);
      check("hold_flags", {28'b0, flag_carry, flag_zero, flag_sign, flag_ovf}, 32'h3);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    op_a = 32'h1;
    op_b = 32'h3;
    check_output();
    sb.push_back(mk(32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(1);
    check_output();

    // Reset two cycles into a 10-bit logical right shift drops the pending result
    tag = "reset_abort";
    apply_stimulus(4'b0111, 32'hFFFFFFFF, 32'd10, mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, 32'd1);
    check("out_valid", {31'b0, out_valid}, 32'd0);
    check("result", result, 32'd0);
    rst   = 1'b0;
    stale = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("stale_out_valid", {31'b0, stale}, 32'd0);
    apply_stimulus(4'b0001, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    wait_valid(1);
    check_output();

    tag = "end";
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
